penta_bcd_editor: RTL

Consumes the five single-cycle debounced button pulses from the five-button debouncer and turns them into a cursor-driven multi-digit BCD value editor.
- Buttons: up, down, left, right, enter.
- The user enters edit mode, changes digits, and commits the result.
- Downstream logic (display driver, setpoint registers) reads the committed value and the live edit shadow.

---
 rtl/penta_bcd_editor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/penta_bcd_editor.sv
// Cursor-driven multi-digit BCD editor fed by five debounced button pulses.
// Optional idle auto-abort in EDIT is enabled by defining EDIT_TIMEOUT_EN.
module penta_bcd_editor #(
   parameter int                  DIGITS         = 4,
   parameter logic [4*DIGITS-1:0] INIT_VALUE     = {(4*DIGITS){1'b0}},
   parameter int                  TIMEOUT_CYCLES = 50000000
) (
   input  logic                  sysclk,
   input  logic                  reset,
   input  logic                  btn_up,
   input  logic                  btn_down,
   input  logic                  btn_left,
   input  logic                  btn_right,
   input  logic                  btn_enter,
   output logic [4*DIGITS-1:0]   value,
   output logic [4*DIGITS-1:0]   edit_value,
   output logic [2:0]            cursor,
   output logic                  editing,
   output logic                  commit_pulse,
   output logic                  abort_pulse
);

   localparam int         DW      = 4 * DIGITS;
   localparam logic [2:0] CUR_MAX = 3'(DIGITS - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EDIT = 1'b1
   } state_t;

   state_t          state_r, next_state_s;
   logic [DW-1:0]   value_nx_s, edit_nx_s;
   logic [2:0]      cursor_nx_s;
   logic            commit_nx_s, abort_nx_s;
   logic            tmo_hit_s;

   // Wrapping single-digit step; out-of-range nibbles are forced back into 0..9.
   function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic inc);
      logic [3:0] r;
      if (inc) begin
         r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
      end else begin
         r = (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] bump(input logic [DW-1:0] v, input logic [2:0] pos,
                                          input logic inc);
      logic [DW-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (3'(i) == pos) begin
            r[4*i +: 4] = bcd_step(v[4*i +: 4], inc);
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

`ifdef EDIT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] tmo_cnt_r;
   logic          any_btn_s;

   assign any_btn_s = btn_up | btn_down | btn_left | btn_right | btn_enter;
   assign tmo_hit_s = (state_r == EDIT) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

   // Idle counter: advances only while staying in EDIT with no button activity.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (state_r == EDIT && next_state_s == EDIT && !any_btn_s) begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
         tmo_cnt_r <= {TW{1'b0}};
      end
   end
`else
   logic unused_cfg_s;
   assign unused_cfg_s = (TIMEOUT_CYCLES > 0);
   assign tmo_hit_s    = 1'b0;
`endif

   // Next-state and next-output decode; buttons resolved enter > up > down > left > right.
   always_comb begin
      next_state_s = state_r;
      value_nx_s   = value;
      edit_nx_s    = edit_value;
      cursor_nx_s  = cursor;
      commit_nx_s  = 1'b0;
      abort_nx_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (btn_enter) begin
               next_state_s = EDIT;
               edit_nx_s    = value;
               cursor_nx_s  = 3'd0;
            end else begin
               next_state_s = IDLE;
            end
         end
         EDIT: begin
            if (btn_enter) begin
               next_state_s = IDLE;
               value_nx_s   = edit_value;
               cursor_nx_s  = 3'd0;
               commit_nx_s  = 1'b1;
            end else if (btn_up) begin
               edit_nx_s = bump(edit_value, cursor, 1'b1);
            end else if (btn_down) begin
               edit_nx_s = bump(edit_value, cursor, 1'b0);
            end else if (btn_left) begin
               cursor_nx_s = (cursor >= CUR_MAX) ? 3'd0 : cursor + 3'd1;
            end else if (btn_right) begin
               cursor_nx_s = (cursor == 3'd0) ? CUR_MAX : cursor - 3'd1;
            end else if (tmo_hit_s) begin
               next_state_s = IDLE;
               edit_nx_s    = value;
               cursor_nx_s  = 3'd0;
               abort_nx_s   = 1'b1;
            end else begin
               next_state_s = EDIT;
            end
         end
         default: begin
            next_state_s = IDLE;
            edit_nx_s    = value;
            cursor_nx_s  = 3'd0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         value        <= INIT_VALUE;
         edit_value   <= INIT_VALUE;
         cursor       <= 3'd0;
         editing      <= 1'b0;
         commit_pulse <= 1'b0;
         abort_pulse  <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         value        <= value_nx_s;
         edit_value   <= edit_nx_s;
         cursor       <= cursor_nx_s;
         editing      <= (next_state_s == EDIT);
         commit_pulse <= commit_nx_s;
         abort_pulse  <= abort_nx_s;
      end
   end

endmodule
